// File: rtl/fft_mem_sequencer.sv
// Address/strobe sequencer for an in-place radix-2 DIT FFT over a single-port working memory.
// Optional inverse-transform twiddle conjugation is enabled by defining FFT_INVERSE_EN.
module fft_mem_sequencer #(
  parameter int LOG2N  = 12,
  parameter int BF_LAT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
`ifdef FFT_INVERSE_EN
  input  logic             inverse,
  output logic             tw_conj,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  output logic [LOG2N-1:0] mem_read_adr,
  output logic [LOG2N-1:0] mem_write_adr,
  output logic             mem_write,
  output logic [1:0]       wr_sel,
  output logic             bf_a_cap,
  output logic             bf_b_cap,
  output logic [LOG2N-2:0] tw_idx,
  output logic [3:0]       stage,
  output logic             busy,
  output logic             out_valid,
  output logic             out_last,
  output logic             done
);

  localparam int N    = 1 << LOG2N;
  localparam int HALF = N / 2;
  localparam int WW   = (BF_LAT > 1) ? $clog2(BF_LAT) : 1;

  localparam logic [LOG2N-1:0] K_LAST = LOG2N'(N - 1);
  localparam logic [LOG2N-2:0] P_LAST = (LOG2N-1)'(HALF - 1);
  localparam logic [3:0]       S_LAST = 4'(LOG2N - 1);
  localparam logic [WW-1:0]    W_LAST = WW'(BF_LAT - 1);

  localparam logic [3:0] ST_IDLE   = 4'd0;
  localparam logic [3:0] ST_LOAD   = 4'd1;
  localparam logic [3:0] ST_FLUSH  = 4'd2;
  localparam logic [3:0] ST_RD_A   = 4'd3;
  localparam logic [3:0] ST_RD_B   = 4'd4;
  localparam logic [3:0] ST_CAP_B  = 4'd5;
  localparam logic [3:0] ST_WAIT   = 4'd6;
  localparam logic [3:0] ST_WR_A   = 4'd7;
  localparam logic [3:0] ST_WR_B   = 4'd8;
  localparam logic [3:0] ST_UNLOAD = 4'd9;
  localparam logic [3:0] ST_DRAIN  = 4'd10;

  logic [3:0]       state_r;
  logic [LOG2N-1:0] k_r;
  logic [LOG2N-2:0] p_r;
  logic [3:0]       s_r;
  logic [WW-1:0]    w_r;
  logic [LOG2N-1:0] r_r;
  logic             ld_wr_r;
  logic             out_valid_r;
  logic             out_last_r;
  logic             done_r;

  logic [LOG2N-2:0] mask_s;
  logic [LOG2N-2:0] hi_s;
  logic [LOG2N-1:0] a_s;
  logic [LOG2N-1:0] b_s;
  logic [LOG2N-2:0] tw_s;
  logic             compute_s;

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
    logic [LOG2N-1:0] res;
    res = '0;
    for (int i = 0; i < LOG2N; i++) res[i] = v[LOG2N-1-i];
    return res;
  endfunction

  // Butterfly operand addresses: a is p with a zero inserted at bit s, b sets that bit.
  always_comb begin
    mask_s    = ((LOG2N-1)'(1) << s_r) - (LOG2N-1)'(1);
    hi_s      = p_r & ~mask_s;
    a_s       = {hi_s, 1'b0} | {1'b0, p_r & mask_s};
    b_s       = a_s | (LOG2N'(1) << s_r);
    tw_s      = (p_r & mask_s) << (S_LAST - s_r);
    compute_s = (state_r >= ST_RD_A) && (state_r <= ST_WR_B);
  end

  // Output decode from phase state and counters.
  always_comb begin
    in_ready      = (state_r == ST_LOAD);
    busy          = (state_r != ST_IDLE);
    bf_a_cap      = (state_r == ST_RD_B);
    bf_b_cap      = (state_r == ST_CAP_B);
    mem_write     = ld_wr_r || (state_r == ST_WR_A) || (state_r == ST_WR_B);
    tw_idx        = compute_s ? tw_s : '0;
    stage         = compute_s ? s_r : 4'd0;
    out_valid     = out_valid_r;
    out_last      = out_last_r;
    done          = done_r;
    case (state_r)
      ST_WR_A: wr_sel = 2'd1;
      ST_WR_B: wr_sel = 2'd2;
      default: wr_sel = 2'd0;
    endcase
    if (state_r == ST_RD_B) begin
      mem_read_adr = b_s;
    end else if (compute_s) begin
      mem_read_adr = a_s;
    end else if (state_r == ST_UNLOAD) begin
      mem_read_adr = r_r;
    end else begin
      mem_read_adr = '0;
    end
    // Write address leads the write by one cycle, so WR_A presents b for the WR_B write.
    if (state_r == ST_LOAD) begin
      mem_write_adr = bitrev(k_r);
    end else if (state_r == ST_WR_A) begin
      mem_write_adr = b_s;
    end else if (compute_s) begin
      mem_write_adr = a_s;
    end else begin
      mem_write_adr = '0;
    end
  end

`ifdef FFT_INVERSE_EN
  logic inv_r;

  // Inverse flag latched with start and only exposed while computing.
  always_ff @(posedge clk) begin
    if (rst) begin
      inv_r <= 1'b0;
    end else if ((state_r == ST_IDLE) && start) begin
      inv_r <= inverse;
    end
  end

  assign tw_conj = inv_r && compute_s;
`endif

  // Phase sequencing and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      k_r         <= '0;
      p_r         <= '0;
      s_r         <= 4'd0;
      w_r         <= '0;
      r_r         <= '0;
      ld_wr_r     <= 1'b0;
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      ld_wr_r     <= (state_r == ST_LOAD) && in_valid;
      out_valid_r <= (state_r == ST_UNLOAD);
      out_last_r  <= (state_r == ST_UNLOAD) && (r_r == K_LAST);
      done_r      <= (state_r == ST_DRAIN);
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_r <= ST_LOAD;
            k_r     <= '0;
          end
        end
        ST_LOAD: begin
          if (in_valid) begin
            if (k_r == K_LAST) begin
              k_r     <= '0;
              state_r <= ST_FLUSH;
            end else begin
              k_r <= k_r + LOG2N'(1);
            end
          end
        end
        ST_FLUSH: begin
          s_r     <= 4'd0;
          p_r     <= '0;
          state_r <= ST_RD_A;
        end
        ST_RD_A:  state_r <= ST_RD_B;
        ST_RD_B:  state_r <= ST_CAP_B;
        ST_CAP_B: begin
          w_r     <= '0;
          state_r <= ST_WAIT;
        end
        ST_WAIT: begin
          if (w_r == W_LAST) begin
            state_r <= ST_WR_A;
          end else begin
            w_r <= w_r + WW'(1);
          end
        end
        ST_WR_A:  state_r <= ST_WR_B;
        ST_WR_B: begin
          state_r <= ST_RD_A;
          if (p_r == P_LAST) begin
            p_r <= '0;
            if (s_r == S_LAST) begin
              s_r     <= 4'd0;
              r_r     <= '0;
              state_r <= ST_UNLOAD;
            end else begin
              s_r <= s_r + 4'd1;
            end
          end else begin
            p_r <= p_r + (LOG2N-1)'(1);
          end
        end
        ST_UNLOAD: begin
          if (r_r == K_LAST) begin
            r_r     <= '0;
            state_r <= ST_DRAIN;
          end else begin
            r_r <= r_r + LOG2N'(1);
          end
        end
        ST_DRAIN: state_r <= ST_IDLE;
        default:  state_r <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/fft_mem_sequencer.md
Name: fft_mem_sequencer

Overview:
Control sequencer for the FFT working memory (single-port 4096x16 buffer: read or write per cycle, write address registered one cycle before data, one-cycle read latency). It runs an in-place radix-2 DIT FFT in three phases.
- LOAD: streams N samples into memory at bit-reversed addresses.
- COMPUTE: issues LOG2N stages of butterfly read/write traffic plus twiddle indices to an external butterfly unit.
- UNLOAD: streams results out in natural order.

It owns no data, only addresses, strobes and mux selects.

Parameters:
- LOG2N, 12, log2 of transform size N; address width; min 2
- BF_LAT, 4, butterfly unit latency in cycles from operand B capture to results valid; min 1

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  begin transform; sampled only in IDLE
- in_valid  in  1  input sample valid during LOAD
- in_ready  out  1  high in LOAD
- mem_read_adr  out  LOG2N  memory read address
- mem_write_adr  out  LOG2N  memory write address, presented one cycle before its write
- mem_write  out  1  memory write enable
- wr_sel  out  2  memory data_in mux: 0 = registered input sample, 1 = butterfly result A, 2 = butterfly result B
- bf_a_cap  out  1  read_data holds operand A this cycle
- bf_b_cap  out  1  read_data holds operand B this cycle
- tw_idx  out  LOG2N-1  twiddle ROM index for current butterfly
- stage  out  4  current stage s
- busy  out  1  high when not IDLE
- out_valid  out  1  read_data is an output sample this cycle
- out_last  out  1  with out_valid on sample N-1
- done  out  1  one-cycle pulse at end of transform

Behaviour:
Reset values and reset handling:
- Reset: state IDLE; all outputs 0; counters cleared.
- rst at any time aborts the transform; mem_write is 0 from the next cycle. Memory contents are then unspecified.

IDLE:
- start=1 -> LOAD with k=0. start while busy is ignored.

LOAD (in_ready=1):
- mem_write_adr = bitrev(k) combinationally from counter k.
- Accept at cycle t (in_valid=1): k increments; at t+1 mem_write=1, wr_sel=0. The datapath supplies the sample registered at t.
- Gaps in in_valid produce no write.
- After accepting k=N-1: in_ready drops the next cycle, the final write completes, then COMPUTE with s=0, p=0.

COMPUTE, butterfly addressing:
- Butterfly index p runs 0..N/2-1.
- a = p with a 0 inserted at bit s; b = a + 2^s.
- j = p mod 2^s; tw_idx = j << (LOG2N-1-s).

COMPUTE, per-butterfly sequence (BF_LAT+5 cycles):
- RD_A: mem_read_adr=a.
- RD_B: mem_read_adr=b, bf_a_cap=1.
- CAP_B: bf_b_cap=1.
- WAIT: BF_LAT cycles.
- WR_A: mem_write=1, wr_sel=1, mem_write_adr=b.
- WR_B: mem_write=1, wr_sel=2.
- mem_write_adr=a in every compute state except WR_A, so the memory's registered write address is a in WR_A and b in WR_B.
- mem_write=0 in all read and wait states.
- tw_idx and stage stay stable from RD_A through WR_B.
- The butterfly unit holds its results until the next bf_a_cap.

COMPUTE, stage and phase transitions:
- After p=N/2-1: s increments and p resets.
- After s=LOG2N-1: go to UNLOAD with r=0.

UNLOAD:
- mem_read_adr=r, one address per cycle; r=0..N-1.
- out_valid asserted one cycle after each address, aligned with read_data.
- out_last accompanies address N-1. No backpressure.
- The cycle after the last out_valid: done=1 and state goes to IDLE.

Other rules:
- Total COMPUTE cycles = LOG2N * N/2 * (BF_LAT+5).
- All counters wrap-free. Terminal counts are compared explicitly, never by overflow.

Optional Feature:
FFT_INVERSE_EN
- Defined: adds input port inverse (1 bit), sampled with start and held for the transform. Adds output tw_conj (1 bit), equal to the latched inverse throughout COMPUTE and 0 otherwise; the twiddle ROM conjugates on it. Reset clears the latch.
- Undefined: both ports absent; forward transform only.

Test Plan:
- Reset: assert rst 2 cycles mid-COMPUTE -> next cycle busy=0, mem_write=0, all outputs 0; new start begins LOAD at k=0.
- LOAD, LOG2N=3, in_valid pattern 1,1,0,1,1,1,1,0,1,1 -> 8 writes, one cycle after each accept, to memory-registered addresses 0,4,2,6,1,5,3,7; wr_sel=0.
- Addressing, LOG2N=3:
  - Stage 0: pairs (0,1)(2,3)(4,5)(6,7), tw 0,0,0,0.
  - Stage 1: (0,2)(1,3)(4,6)(5,7), tw 0,2,0,2.
  - Stage 2: (0,4)(1,5)(2,6)(3,7), tw 0,1,2,3.
  - Each butterfly spans exactly 9 cycles at BF_LAT=4.
- Timing: bf_a_cap exactly one cycle after RD_A address and bf_b_cap exactly two cycles after; COMPUTE spans 108 cycles for LOG2N=3, BF_LAT=4.
- End-to-end, LOG2N=3, behavioural memory + butterfly model, input impulse x[0]=1 -> unload 8 equal samples in order; out_last on 8th; done pulses the following cycle; start during busy ignored.
- FFT_INVERSE_EN defined: start with inverse=1 -> tw_conj=1 for all of COMPUTE and 0 in LOAD and UNLOAD; with inverse=0 -> tw_conj stays 0.
